// File: rtl/board_mem_arbiter_if.sv
// Signal bundle for board_mem_arbiter: clear control, game-write and read requesters,
// and the single shared board memory port.
interface board_mem_arbiter_if #(
    parameter int COL_BITS = 6
);
    logic                clear_req;
    logic                clear_busy;
    logic                clear_done;

    logic                wr_req;
    logic [2:0]          wr_addr;
    logic [COL_BITS-1:0] wr_onoff;
    logic [COL_BITS-1:0] wr_player;
    logic                wr_gnt;

    logic                rd_req;
    logic [2:0]          rd_addr;
    logic                rd_gnt;
    logic                rd_valid;
    logic [COL_BITS-1:0] rd_onoff;
    logic [COL_BITS-1:0] rd_player;

    logic [2:0]          mem_addr;
    logic                mem_we;
    logic [COL_BITS-1:0] mem_wdata_onoff;
    logic [COL_BITS-1:0] mem_wdata_player;
    logic [COL_BITS-1:0] mem_rdata_onoff;
    logic [COL_BITS-1:0] mem_rdata_player;

    logic                addr_err;

    // Requesters plus the memory's read-data return path.
    modport master (
        output clear_req, wr_req, wr_addr, wr_onoff, wr_player, rd_req, rd_addr,
               mem_rdata_onoff, mem_rdata_player,
        input  clear_busy, clear_done, wr_gnt, rd_gnt, rd_valid, rd_onoff, rd_player,
               mem_addr, mem_we, mem_wdata_onoff, mem_wdata_player, addr_err
    );

    modport slave (
        input  clear_req, wr_req, wr_addr, wr_onoff, wr_player, rd_req, rd_addr,
               mem_rdata_onoff, mem_rdata_player,
        output clear_busy, clear_done, wr_gnt, rd_gnt, rd_valid, rd_onoff, rd_player,
               mem_addr, mem_we, mem_wdata_onoff, mem_wdata_player, addr_err
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// Shares one board memory port between a clear sweep, a game writer and a reader.
// Define ARB_READ_FAIR_EN to stop a continuously writing requester from starving the reader.
module board_mem_arbiter #(
    parameter int NUM_COLS = 7,
    parameter int COL_BITS = 6
) (
    input logic                clk,
    input logic                reset,
    board_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam logic [2:0]          LAST_COL  = 3'(NUM_COLS - 1);
    localparam logic [3:0]          COL_LIMIT = 4'(NUM_COLS);
    localparam logic [COL_BITS-1:0] ZERO      = '0;

    state_t     state;
    logic [2:0] col_cnt;
    logic       busy_q;
    logic       done_q;
    logic       arb_open;
    logic       rd_wins;
    logic       wr_win;
    logic       rd_win;
    logic       wr_oob;
    logic       rd_oob;
    logic       rd_valid_q;
    logic       rd_oob_q;
    logic       addr_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            col_cnt <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear_req) begin
                        state   <= CLEAR;
                        col_cnt <= 3'd0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    col_cnt <= col_cnt + 3'd1;
                    if (col_cnt == LAST_COL) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A clear request in IDLE takes the cycle, so arbitration only opens without one.
    assign arb_open = !reset && (state == IDLE) && !bus.clear_req;
    assign wr_oob   = {1'b0, bus.wr_addr} >= COL_LIMIT;
    assign rd_oob   = {1'b0, bus.rd_addr} >= COL_LIMIT;

`ifdef ARB_READ_FAIR_EN
    logic [1:0] starve_cnt;

    assign rd_wins = bus.rd_req && (!bus.wr_req || (starve_cnt == 2'd2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 2'd0;
        end else if (!bus.rd_req || rd_win) begin
            starve_cnt <= 2'd0;
        end else if (wr_win && (starve_cnt != 2'd2)) begin
            starve_cnt <= starve_cnt + 2'd1;
        end
    end
`else
    assign rd_wins = bus.rd_req && !bus.wr_req;
`endif

    assign wr_win = arb_open && bus.wr_req && !rd_wins;
    assign rd_win = arb_open && rd_wins;

    always_comb begin
        bus.mem_addr         = 3'd0;
        bus.mem_we           = 1'b0;
        bus.mem_wdata_onoff  = ZERO;
        bus.mem_wdata_player = ZERO;
        if (state == CLEAR) begin
            bus.mem_addr = col_cnt;
            bus.mem_we   = 1'b1;
        end else if (wr_win) begin
            bus.mem_addr         = bus.wr_addr;
            bus.mem_we           = !wr_oob;
            bus.mem_wdata_onoff  = bus.wr_onoff;
            bus.mem_wdata_player = bus.wr_player;
        end else if (rd_win) begin
            bus.mem_addr = bus.rd_addr;
        end
    end

    // Memory read data lands one cycle after the grant; out-of-range reads return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_win;
            rd_oob_q   <= rd_win && rd_oob;
            addr_err_q <= (wr_win && wr_oob) || (rd_win && rd_oob);
        end
    end

    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;
    assign bus.wr_gnt     = wr_win;
    assign bus.rd_gnt     = rd_win;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_onoff   = (rd_valid_q && !rd_oob_q) ? bus.mem_rdata_onoff : ZERO;
    assign bus.rd_player  = (rd_valid_q && !rd_oob_q) ? bus.mem_rdata_player : ZERO;
    assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_board_mem_arbiter.sv
// Randomized scoreboard bench for board_mem_arbiter, with a behavioural model of the
// sweep, arbitration and board contents; honours ARB_READ_FAIR_EN.
module tb_board_mem_arbiter;
    localparam int NUM_COLS = 7;
    localparam int COL_BITS = 6;
`ifdef ARB_READ_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        int                  due;
        logic [COL_BITS-1:0] on;
        logic [COL_BITS-1:0] pl;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset;

    board_mem_arbiter_if #(.COL_BITS(COL_BITS)) bus ();

    board_mem_arbiter #(.NUM_COLS(NUM_COLS), .COL_BITS(COL_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Board memory: synchronous read; column 7 does not exist and floats to a junk pattern.
    logic [COL_BITS-1:0] mem_on [0:7];
    logic [COL_BITS-1:0] mem_pl [0:7];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            mem_on[bus.mem_addr] <= bus.mem_wdata_onoff;
            mem_pl[bus.mem_addr] <= bus.mem_wdata_player;
        end
        if (int'(bus.mem_addr) < NUM_COLS) begin
            bus.mem_rdata_onoff  <= mem_on[bus.mem_addr];
            bus.mem_rdata_player <= mem_pl[bus.mem_addr];
        end else begin
            bus.mem_rdata_onoff  <= 6'h2A;
            bus.mem_rdata_player <= 6'h15;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sweep_pos = -1;
    int starve = 0;
    int rd_gnt_seen = 0;
    int done_seen = 0;
    bit wr_pending = 1'b0;
    bit rd_pending = 1'b0;
    logic [COL_BITS-1:0] ref_on [0:7];
    logic [COL_BITS-1:0] ref_pl [0:7];
    rd_exp_t rd_q[$];
    int err_q[$];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model step: predicts this cycle's combinational outputs and queues later ones.
    task automatic check_output();
        bit                  e_wr;
        bit                  e_rd;
        bit                  e_we;
        bit                  e_busy;
        bit                  e_done;
        logic [2:0]          e_addr;
        logic [11:0]         e_wd;
        int                  a;
        rd_exp_t             r;
        e_wr = 0; e_rd = 0; e_we = 0; e_busy = 0; e_done = 0;
        e_addr = 3'd0;
        e_wd = 12'd0;
        if (reset) begin
            sweep_pos = -1;
            starve = 0;
            rd_q.delete();
            err_q.delete();
            compare("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
            compare("reset_addr_err", 32'(bus.addr_err), 32'd0);
        end else if (sweep_pos >= 0 && sweep_pos < NUM_COLS) begin
            e_busy = 1;
            e_we = 1;
            e_addr = 3'(sweep_pos);
            ref_on[sweep_pos] = '0;
            ref_pl[sweep_pos] = '0;
            sweep_pos++;
        end else if (sweep_pos == NUM_COLS) begin
            e_busy = 1;
            e_done = 1;
            sweep_pos = -1;
        end else if (bus.clear_req) begin
            sweep_pos = 0;
        end else begin
            e_rd = bus.rd_req && (!bus.wr_req || (FAIR && starve >= 2));
            e_wr = bus.wr_req && !e_rd;
            if (e_wr) begin
                a = int'(bus.wr_addr);
                e_addr = bus.wr_addr;
                e_wd = {bus.wr_onoff, bus.wr_player};
                if (a < NUM_COLS) begin
                    e_we = 1;
                    ref_on[a] = bus.wr_onoff;
                    ref_pl[a] = bus.wr_player;
                end else begin
                    err_q.push_back(cyc + 1);
                end
            end else if (e_rd) begin
                a = int'(bus.rd_addr);
                e_addr = bus.rd_addr;
                r.due = cyc + 1;
                r.on = (a < NUM_COLS) ? ref_on[a] : '0;
                r.pl = (a < NUM_COLS) ? ref_pl[a] : '0;
                rd_q.push_back(r);
                if (a >= NUM_COLS) err_q.push_back(cyc + 1);
            end
        end
        if (!reset) begin
            if (!bus.rd_req || e_rd) starve = 0;
            else if (e_wr) starve++;
        end
        compare("wr_gnt", 32'(bus.wr_gnt), 32'(e_wr));
        compare("rd_gnt", 32'(bus.rd_gnt), 32'(e_rd));
        compare("mem_we", 32'(bus.mem_we), 32'(e_we));
        compare("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        compare("mem_wdata", 32'({bus.mem_wdata_onoff, bus.mem_wdata_player}), 32'(e_wd));
        compare("clear_busy", 32'(bus.clear_busy), 32'(e_busy));
        compare("clear_done", 32'(bus.clear_done), 32'(e_done));
        if (bus.rd_gnt === 1'b1) rd_gnt_seen++;
        if (bus.clear_done === 1'b1) done_seen++;
        if (e_wr) wr_pending = 0;
        if (e_rd) rd_pending = 0;
        cyc++;
    endtask

    // One clock of stimulus; a pending request is held unchanged until it is granted.
    task automatic apply_stimulus(input bit rst, input bit clr, input bit new_wr,
                                  input logic [2:0] wa, input logic [5:0] won,
                                  input logic [5:0] wpl, input bit new_rd, input logic [2:0] ra);
        @(negedge clk);
        reset = rst;
        bus.clear_req = clr;
        if (!wr_pending) begin
            bus.wr_req = new_wr;
            bus.wr_addr = wa;
            bus.wr_onoff = won;
            bus.wr_player = wpl;
            wr_pending = new_wr;
        end
        if (!rd_pending) begin
            bus.rd_req = new_rd;
            bus.rd_addr = ra;
            rd_pending = new_rd;
        end
        #2;
        check_output();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
    endtask

    // Registered outputs are checked just after the edge, against expectations queued earlier.
    task automatic run_monitor();
        bit      exp_v;
        bit      exp_e;
        rd_exp_t r;
        forever begin
            @(posedge clk);
            #1;
            exp_v = (rd_q.size() > 0) && (rd_q[0].due == cyc);
            compare("rd_valid", 32'(bus.rd_valid), 32'(exp_v));
            if (exp_v) begin
                r = rd_q.pop_front();
                compare("rd_data", 32'({bus.rd_onoff, bus.rd_player}), 32'({r.on, r.pl}));
            end
            exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
            compare("addr_err", 32'(bus.addr_err), 32'(exp_e));
            if (exp_e) void'(err_q.pop_front());
        end
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        bus.clear_req = 0;
        bus.wr_req = 0; bus.wr_addr = 0; bus.wr_onoff = 0; bus.wr_player = 0;
        bus.rd_req = 0; bus.rd_addr = 0;
        for (int i = 0; i < 8; i++) begin
            ref_on[i] = '0;
            ref_pl[i] = '0;
        end
        fork
            run_monitor();
        join_none

        apply_stimulus(1, 0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
        apply_stimulus(1, 0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);

        // Full sweep from a one-cycle clear pulse.
        done_seen = 0;
        apply_stimulus(0, 1, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
        idle_cycles(10);
        compare("sweep_done_pulses", 32'(done_seen), 32'd1);

        // Write then read the same column on consecutive cycles.
        apply_stimulus(0, 0, 1, 3'd3, 6'b000001, 6'b000001, 0, 3'd0);
        apply_stimulus(0, 0, 0, 3'd0, 6'd0, 6'd0, 1, 3'd3);
        idle_cycles(2);

        // Both requesters held continuously.
        rd_gnt_seen = 0;
        for (int i = 0; i < 12; i++)
            apply_stimulus(0, 0, 1, 3'd2, 6'(i), 6'(i + 5), 1, 3'd2);
        compare("contended_rd_grants", 32'(rd_gnt_seen), FAIR ? 32'd4 : 32'd0);
        idle_cycles(3);

        // Out-of-range column for both requesters.
        apply_stimulus(0, 0, 1, 3'd7, 6'h3F, 6'h3F, 0, 3'd0);
        apply_stimulus(0, 0, 0, 3'd0, 6'd0, 6'd0, 1, 3'd7);
        idle_cycles(2);

        // Clear request mid-sweep must not restart or extend it.
        done_seen = 0;
        apply_stimulus(0, 1, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
        apply_stimulus(0, 0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
        apply_stimulus(0, 1, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
        idle_cycles(8);
        compare("mid_clear_done_pulses", 32'(done_seen), 32'd1);

        // Reset landing on column 4 aborts the sweep with no done pulse.
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, 3'(i), 6'h2B, 6'h14, 0, 3'd0);
        done_seen = 0;
        apply_stimulus(0, 1, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
        guard = 0;
        while (sweep_pos != 4 && guard < 12) begin
            apply_stimulus(0, 0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
            guard++;
        end
        apply_stimulus(1, 0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
        apply_stimulus(1, 0, 0, 3'd0, 6'd0, 6'd0, 0, 3'd0);
        idle_cycles(10);
        compare("aborted_sweep_done_pulses", 32'(done_seen), 32'd0);
        for (int i = 0; i < NUM_COLS; i++) apply_stimulus(0, 0, 0, 3'd0, 6'd0, 6'd0, 1, 3'(i));

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus($urandom_range(0, 199) == 0,
                           $urandom_range(0, 39) == 0,
                           1'($urandom_range(0, 1)),
                           3'($urandom_range(0, 7)),
                           6'($urandom), 6'($urandom),
                           1'($urandom_range(0, 1)),
                           3'($urandom_range(0, 7)));
        end

        wr_pending = 0;
        rd_pending = 0;
        idle_cycles(12);
        @(posedge clk);
        #2;
        compare("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        compare("err_queue_drained", 32'(err_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
